// File: rtl/vp_arbiter.sv
// Round-robin arbiter sharing one vector processor among NUM_REQ lanes, one op in flight.
// Optional watchdog on the result wait is built when VP_ARB_TIMEOUT_EN is defined.
module vp_arbiter #(
  parameter int DATA_WIDTH     = 16,
  parameter int VECTOR_WIDTH   = 4,
  parameter int NUM_REQ        = 4,
  parameter int REQ_ID_WIDTH   = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic [NUM_REQ-1:0]                           req,
  input  logic [NUM_REQ*4-1:0]                         req_op,
  input  logic [NUM_REQ*VECTOR_WIDTH*DATA_WIDTH-1:0]   req_vec_a,
  input  logic [NUM_REQ*VECTOR_WIDTH*DATA_WIDTH-1:0]   req_vec_b,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]                req_scalar,
  output logic [NUM_REQ-1:0]                           req_ack,
  output logic [NUM_REQ-1:0]                           rsp_valid,
  output logic [VECTOR_WIDTH*DATA_WIDTH-1:0]           rsp_result,
  output logic [NUM_REQ-1:0]                           rsp_timeout,
  output logic [REQ_ID_WIDTH-1:0]                      owner_id,
  output logic                                         arb_busy,
  output logic                                         vp_start,
  output logic [3:0]                                   vp_operation,
  output logic [VECTOR_WIDTH*DATA_WIDTH-1:0]           vp_vec_a,
  output logic [VECTOR_WIDTH*DATA_WIDTH-1:0]           vp_vec_b,
  output logic [DATA_WIDTH-1:0]                        vp_scalar,
  input  logic                                         vp_busy,
  input  logic                                         vp_done,
  input  logic [VECTOR_WIDTH*DATA_WIDTH-1:0]           vp_result,
  input  logic                                         vp_result_valid
);

  localparam int VW = VECTOR_WIDTH * DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                    state;
  logic [REQ_ID_WIDTH-1:0]   rr_ptr;

  logic [2*NUM_REQ-1:0]      req_rot;
  logic                      gnt_vld;
  int                        gnt_win;
  logic [REQ_ID_WIDTH-1:0]   gnt_idx;
  logic [REQ_ID_WIDTH-1:0]   ptr_nxt;
  logic [3:0]                gnt_op;
  logic [VW-1:0]             gnt_a;
  logic [VW-1:0]             gnt_b;
  logic [DATA_WIDTH-1:0]     gnt_s;

`ifdef VP_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0]             wd_cnt;
`else
  logic                      unused_vp_done;
  assign unused_vp_done = vp_done;
  assign rsp_timeout    = '0;
`endif

  // Rotate so bit 0 is the lane at rr_ptr; the lowest set bit then wins.
  assign req_rot = {req, req} >> rr_ptr;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_win = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        gnt_vld = 1'b1;
        gnt_win = int'(rr_ptr) + i;
      end
    end
    if (gnt_win >= NUM_REQ) gnt_win = gnt_win - NUM_REQ;
    gnt_idx = REQ_ID_WIDTH'(gnt_win);
    ptr_nxt = (gnt_win == NUM_REQ - 1) ? '0 : REQ_ID_WIDTH'(gnt_win + 1);
    gnt_op  = '0;
    gnt_a   = '0;
    gnt_b   = '0;
    gnt_s   = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (j == gnt_win) begin
        gnt_op = req_op[j*4 +: 4];
        gnt_a  = req_vec_a[j*VW +: VW];
        gnt_b  = req_vec_b[j*VW +: VW];
        gnt_s  = req_scalar[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      rr_ptr       <= '0;
      owner_id     <= '0;
      arb_busy     <= 1'b0;
      vp_start     <= 1'b0;
      req_ack      <= '0;
      rsp_valid    <= '0;
      rsp_result   <= '0;
      vp_operation <= '0;
      vp_vec_a     <= '0;
      vp_vec_b     <= '0;
      vp_scalar    <= '0;
`ifdef VP_ARB_TIMEOUT_EN
      wd_cnt       <= '0;
      rsp_timeout  <= '0;
`endif
    end else begin
      vp_start  <= 1'b0;
      req_ack   <= '0;
      rsp_valid <= '0;
`ifdef VP_ARB_TIMEOUT_EN
      rsp_timeout <= '0;
`endif
      case (state)
        S_IDLE: begin
          if (gnt_vld && !vp_busy) begin
            state        <= S_ISSUE;
            arb_busy     <= 1'b1;
            vp_start     <= 1'b1;
            req_ack      <= NUM_REQ'(1) << gnt_idx;
            owner_id     <= gnt_idx;
            rr_ptr       <= ptr_nxt;
            vp_operation <= gnt_op;
            vp_vec_a     <= gnt_a;
            vp_vec_b     <= gnt_b;
            vp_scalar    <= gnt_s;
          end
        end
        S_ISSUE: begin
          if (vp_result_valid) begin
            state      <= S_RESP;
            rsp_result <= vp_result;
            rsp_valid  <= NUM_REQ'(1) << owner_id;
          end else begin
            state <= S_WAIT;
`ifdef VP_ARB_TIMEOUT_EN
            wd_cnt <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (vp_result_valid) begin
            state      <= S_RESP;
            rsp_result <= vp_result;
            rsp_valid  <= NUM_REQ'(1) << owner_id;
          end
`ifdef VP_ARB_TIMEOUT_EN
          // A real result on the expiry cycle takes the branch above instead.
          else if (wd_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            state       <= S_RESP;
            rsp_result  <= '0;
            rsp_valid   <= NUM_REQ'(1) << owner_id;
            rsp_timeout <= NUM_REQ'(1) << owner_id;
          end else if (vp_done) begin
            wd_cnt <= '0;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        S_RESP: begin
          state    <= S_IDLE;
          arb_busy <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
